// File: rtl/elevator_n.sv
// N-floor elevator controller. Hall and car calls are latched into pending
// vectors, and a collective-selective scheduler picks stops and direction.
module elevator_n #(
  parameter int FLOORS        = 8,
  parameter int FW            = $clog2(FLOORS),
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] u,
  input  logic [FLOORS-1:0] d,
  input  logic [FLOORS-1:0] i,
  output logic [FW-1:0]     F,
  output logic [1:0]        dir,
  output logic              door,
  output logic [FLOORS-1:0] up_pend,
  output logic [FLOORS-1:0] dn_pend,
  output logic [FLOORS-1:0] car_pend
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOORS-1:0] ONE = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0] TOP = ONE << (FLOORS - 1);
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, OPEN} state_t;

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt;
  logic            srv_up;
  logic            srv_dn;

  logic [FLOORS-1:0] u_req, d_req, all_pend, f_oh, nf_oh;
  logic [FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic [FLOORS-1:0] up_next, dn_next, car_next;
  logic [FW-1:0]     nf;
  logic              going_up, at_f, above_f, below_f;
  logic              beyond_f, opp_f, beyond_nf, same_nf, stop_nf, door_call;
  logic              clear_wins;

  assign u_req     = u & ~TOP;
  assign d_req     = d & ~ONE;
  assign all_pend  = up_pend | dn_pend | car_pend;
  assign going_up  = (dir == DIR_UP);
  assign nf        = going_up ? F + FW'(1) : F - FW'(1);
  assign f_oh      = ONE << F;
  assign nf_oh     = ONE << nf;
  assign at_f      = all_pend[F];
  assign above_f   = |(all_pend >> (int'(F) + 1));
  assign below_f   = |(all_pend << (FLOORS - int'(F)));
  assign beyond_f  = going_up ? above_f : below_f;
  assign opp_f     = going_up ? below_f : above_f;
  assign beyond_nf = going_up ? |(all_pend >> (int'(nf) + 1))
                              : |(all_pend << (FLOORS - int'(nf)));
  assign same_nf   = going_up ? up_pend[nf] : dn_pend[nf];
  assign stop_nf   = car_pend[nf] | same_nf | ~beyond_nf;
  assign door_call = i[F] | (srv_up & u_req[F]) | (srv_dn & d_req[F]);

  // Bits serviced this edge; only a car standing open at the floor beats a new call.
  always_comb begin
    clr_up     = '0;
    clr_dn     = '0;
    clr_car    = '0;
    clear_wins = 1'b0;
    case (state)
      IDLE: begin
        if (at_f) begin
          clr_up  = f_oh;
          clr_dn  = f_oh;
          clr_car = f_oh;
        end
      end
      MOVE: begin
        if (tcnt == '0 && stop_nf) begin
          clr_car = nf_oh;
          if (going_up || !beyond_nf) clr_up = nf_oh;
          if (!going_up || !beyond_nf) clr_dn = nf_oh;
        end
      end
      OPEN: begin
        clear_wins = 1'b1;
        clr_car    = f_oh;
        if (srv_up) clr_up = f_oh;
        if (srv_dn) clr_dn = f_oh;
      end
      default: ;
    endcase
    if (clear_wins) begin
      up_next  = (up_pend | u_req) & ~clr_up;
      dn_next  = (dn_pend | d_req) & ~clr_dn;
      car_next = (car_pend | i) & ~clr_car;
    end else begin
      up_next  = (up_pend & ~clr_up) | u_req;
      dn_next  = (dn_pend & ~clr_dn) | d_req;
      car_next = (car_pend & ~clr_car) | i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      F        <= '0;
      dir      <= DIR_IDLE;
      door     <= 1'b0;
      tcnt     <= '0;
      dcnt     <= '0;
      srv_up   <= 1'b0;
      srv_dn   <= 1'b0;
      up_pend  <= '0;
      dn_pend  <= '0;
      car_pend <= '0;
    end else begin
      up_pend  <= up_next;
      dn_pend  <= dn_next;
      car_pend <= car_next;
      case (state)
        IDLE: begin
          // Opening from rest takes an up heading so the departure rule favours above.
          if (at_f) begin
            state  <= OPEN;
            door   <= 1'b1;
            dir    <= DIR_UP;
            dcnt   <= D_LOAD;
            srv_up <= 1'b1;
            srv_dn <= 1'b1;
          end else if (above_f) begin
            state <= MOVE;
            dir   <= DIR_UP;
            tcnt  <= T_LOAD;
          end else if (below_f) begin
            state <= MOVE;
            dir   <= DIR_DN;
            tcnt  <= T_LOAD;
          end
        end
        MOVE: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - TW'(1);
          end else begin
            F    <= nf;
            tcnt <= T_LOAD;
            if (stop_nf) begin
              state  <= OPEN;
              door   <= 1'b1;
              dcnt   <= D_LOAD;
              srv_up <= going_up | ~beyond_nf;
              srv_dn <= ~going_up | ~beyond_nf;
            end
          end
        end
        OPEN: begin
          if (door_call) begin
            dcnt <= D_LOAD;
          end else if (dcnt != '0) begin
            dcnt <= dcnt - DW'(1);
          end else begin
            door   <= 1'b0;
            srv_up <= 1'b0;
            srv_dn <= 1'b0;
            if (beyond_f) begin
              state <= MOVE;
              tcnt  <= T_LOAD;
            end else if (opp_f) begin
              state <= MOVE;
              tcnt  <= T_LOAD;
              dir   <= going_up ? DIR_DN : DIR_UP;
            end else begin
              state <= IDLE;
              dir   <= DIR_IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_n.sv
// Directed bench for elevator_n with a floor-by-floor behavioural model checked
// every cycle, plus literal checkpoints taken from the expected ride sequences.
module tb_elevator_n;

  localparam int FLOORS = 4;
  localparam int FW     = 2;
  localparam int TRAVEL = 2;
  localparam int DOORC  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [FLOORS-1:0] u = '0, d = '0, i = '0;
  logic [FW-1:0]     F;
  logic [1:0]        dir;
  logic              door;
  logic [FLOORS-1:0] up_pend, dn_pend, car_pend;

  int total = 0;
  int bad   = 0;

  elevator_n #(.FLOORS(FLOORS), .FW(FW), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOORC)) dut (
    .clk(clk), .reset(reset), .u(u), .d(d), .i(i),
    .F(F), .dir(dir), .door(door),
    .up_pend(up_pend), .dn_pend(dn_pend), .car_pend(car_pend)
  );

  always #5 clk = ~clk;

  // Model: mode 0 rest, 1 travelling, 2 doors open; heading +1 up, -1 down, 0 none.
  bit mu[FLOORS], md[FLOORS], mc[FLOORS];
  int mfloor = 0, mhead = 0, mmode = 0, travel_left = 0, door_left = 0;
  bit serve_up = 0, serve_dn = 0, model_ready = 0;

  function automatic bit any_in(int lo, int hi);
    for (int f = lo; f <= hi; f++)
      if (mu[f] || md[f] || mc[f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit beyond(int f, int h);
    return (h > 0) ? any_in(f + 1, FLOORS - 1) : any_in(0, f - 1);
  endfunction

  function automatic logic [FLOORS-1:0] pack(input bit a[FLOORS]);
    logic [FLOORS-1:0] v;
    for (int f = 0; f < FLOORS; f++) v[f] = a[f];
    return v;
  endfunction

  function automatic logic [1:0] head_code(int h);
    return (h > 0) ? 2'b01 : ((h < 0) ? 2'b10 : 2'b00);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < FLOORS; f++) begin
      mu[f] = 0; md[f] = 0; mc[f] = 0;
    end
    mfloor = 0; mhead = 0; mmode = 0; travel_left = 0; door_left = 0;
    serve_up = 0; serve_dn = 0;
  endtask

  task automatic model_step();
    bit cu[FLOORS];
    bit cd[FLOORS];
    bit cc[FLOORS];
    bit clear_wins, far, stop, recall, su, sd;
    int nf;
    for (int f = 0; f < FLOORS; f++) begin
      cu[f] = 0; cd[f] = 0; cc[f] = 0;
    end
    clear_wins = 0;
    case (mmode)
      0: begin
        if (mu[mfloor] || md[mfloor] || mc[mfloor]) begin
          mmode = 2; mhead = 1; door_left = DOORC; serve_up = 1; serve_dn = 1;
          cu[mfloor] = 1; cd[mfloor] = 1; cc[mfloor] = 1;
        end else if (beyond(mfloor, 1)) begin
          mmode = 1; mhead = 1; travel_left = TRAVEL;
        end else if (beyond(mfloor, -1)) begin
          mmode = 1; mhead = -1; travel_left = TRAVEL;
        end
      end
      1: begin
        travel_left--;
        if (travel_left == 0) begin
          nf   = mfloor + mhead;
          far  = beyond(nf, mhead);
          stop = mc[nf] || (mhead > 0 ? mu[nf] : md[nf]) || !far;
          mfloor = nf;
          travel_left = TRAVEL;
          if (stop) begin
            mmode = 2; door_left = DOORC;
            serve_up = (mhead > 0) || !far;
            serve_dn = (mhead < 0) || !far;
            cc[nf] = 1; cu[nf] = serve_up; cd[nf] = serve_dn;
          end
        end
      end
      default: begin
        clear_wins = 1;
        cc[mfloor] = 1; cu[mfloor] = serve_up; cd[mfloor] = serve_dn;
        recall = i[mfloor] || (serve_up && u[mfloor] && mfloor != FLOORS - 1)
                 || (serve_dn && d[mfloor] && mfloor != 0);
        if (recall) door_left = DOORC;
        else begin
          door_left--;
          if (door_left == 0) begin
            serve_up = 0; serve_dn = 0;
            if (beyond(mfloor, mhead)) begin
              mmode = 1; travel_left = TRAVEL;
            end else if (beyond(mfloor, -mhead)) begin
              mmode = 1; travel_left = TRAVEL; mhead = -mhead;
            end else begin
              mmode = 0; mhead = 0;
            end
          end
        end
      end
    endcase
    for (int f = 0; f < FLOORS; f++) begin
      su = u[f] && (f != FLOORS - 1);
      sd = d[f] && (f != 0);
      if (clear_wins) begin
        mu[f] = (mu[f] | su) & ~cu[f];
        md[f] = (md[f] | sd) & ~cd[f];
        mc[f] = (mc[f] | i[f]) & ~cc[f];
      end else begin
        mu[f] = (mu[f] & ~cu[f]) | su;
        md[f] = (md[f] & ~cd[f]) | sd;
        mc[f] = (mc[f] & ~cc[f]) | i[f];
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      model_ready <= 1'b1;
    end else begin
      model_step();
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      check_output("model_F", 32'(F), 32'(mfloor));
      check_output("model_dir", 32'(dir), 32'(head_code(mhead)));
      check_output("model_door", 32'(door), 32'(mmode == 2));
      check_output("model_up_pend", 32'(up_pend), 32'(pack(mu)));
      check_output("model_dn_pend", 32'(dn_pend), 32'(pack(md)));
      check_output("model_car_pend", 32'(car_pend), 32'(pack(mc)));
    end
  end

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait expired, required event never seen", name);
  endtask

  task automatic apply_stimulus(input logic [FLOORS-1:0] uv, input logic [FLOORS-1:0] dv,
                                input logic [FLOORS-1:0] iv);
    u = uv; d = dv; i = iv;
    @(negedge clk);
    u = '0; d = '0; i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("reset_F", 32'(F), 32'(0));
    check_output("reset_dir", 32'(dir), 32'(0));
    check_output("reset_door", 32'(door), 32'(0));
    check_output("reset_pend", 32'({up_pend, dn_pend, car_pend}), 32'(0));
  endtask

  task automatic wait_door(input logic level, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (door === level) return;
    end
    timeout(level ? "wait_door_open" : "wait_door_closed");
  endtask

  task automatic wait_floor(input logic [FW-1:0] f, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (F === f) return;
    end
    timeout("wait_floor");
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (door === 1'b0 && dir === 2'b00 && {up_pend, dn_pend, car_pend} === '0) return;
    end
    timeout("wait_idle");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // Single car call to the top floor from rest.
    apply_stimulus('0, '0, 4'b1000);
    check_output("t1_latched", 32'(car_pend), 32'(4'b1000));
    check_output("t1_still_idle", 32'(dir), 32'(2'b00));
    @(negedge clk);
    check_output("t1_depart_dir", 32'(dir), 32'(2'b01));
    check_output("t1_depart_F", 32'(F), 32'(0));
    repeat (2) @(negedge clk);
    check_output("t1_F1", 32'(F), 32'(1));
    repeat (4) @(negedge clk);
    check_output("t1_F3", 32'(F), 32'(3));
    check_output("t1_door_open", 32'(door), 32'(1));
    check_output("t1_car_clear", 32'(car_pend), 32'(0));
    repeat (2) @(negedge clk);
    check_output("t1_door_last", 32'(door), 32'(1));
    @(negedge clk);
    check_output("t1_door_closed", 32'(door), 32'(0));
    check_output("t1_idle_dir", 32'(dir), 32'(2'b00));

    // Hall up-call picked up on the way.
    do_reset();
    u = '0; d = '0; i = 4'b1000;
    @(negedge clk);
    apply_stimulus(4'b0010, '0, '0);
    wait_door(1'b1, 20);
    check_output("t2_stop_F", 32'(F), 32'(1));
    check_output("t2_up_clear", 32'(up_pend), 32'(0));
    wait_door(1'b0, 20);
    wait_door(1'b1, 20);
    check_output("t2_final_F", 32'(F), 32'(3));
    wait_idle(30);

    // Descending from the top with calls below.
    do_reset();
    apply_stimulus('0, '0, 4'b1000);
    wait_idle(40);
    check_output("t3_start_F", 32'(F), 32'(3));
    apply_stimulus('0, 4'b0100, 4'b0001);
    wait_door(1'b1, 20);
    check_output("t3_stop2_F", 32'(F), 32'(2));
    check_output("t3_dn_clear", 32'(dn_pend), 32'(0));
    wait_door(1'b0, 20);
    apply_stimulus('0, 4'b0010, '0);
    wait_door(1'b1, 20);
    check_output("t3_stop1_F", 32'(F), 32'(1));
    check_output("t3_dn1_clear", 32'(dn_pend), 32'(0));
    wait_door(1'b0, 20);
    wait_door(1'b1, 20);
    check_output("t3_stop0_F", 32'(F), 32'(0));
    wait_idle(30);

    // Down-call behind the car served after reversing at the top.
    do_reset();
    apply_stimulus('0, '0, 4'b1000);
    wait_floor(2'd2, 20);
    apply_stimulus('0, 4'b0010, '0);
    wait_door(1'b1, 20);
    check_output("t4_top_F", 32'(F), 32'(3));
    wait_door(1'b0, 20);
    check_output("t4_reverse_dir", 32'(dir), 32'(2'b10));
    wait_door(1'b1, 20);
    check_output("t4_stop_F", 32'(F), 32'(1));
    check_output("t4_dn_clear", 32'(dn_pend), 32'(0));
    wait_idle(30);

    // Door re-opened by a repeated car call; edge hall bits ignored.
    do_reset();
    apply_stimulus('0, '0, 4'b0100);
    wait_door(1'b1, 20);
    check_output("t5_open_F", 32'(F), 32'(2));
    @(negedge clk);
    apply_stimulus(4'b1000, 4'b0001, 4'b0100);
    check_output("t5_pend_clear", 32'({up_pend, dn_pend, car_pend}), 32'(0));
    check_output("t5_door_a", 32'(door), 32'(1));
    @(negedge clk);
    check_output("t5_door_b", 32'(door), 32'(1));
    @(negedge clk);
    check_output("t5_door_c", 32'(door), 32'(1));
    @(negedge clk);
    check_output("t5_door_shut", 32'(door), 32'(0));
    check_output("t5_dir_idle", 32'(dir), 32'(2'b00));

    // Reset between floors 1 and 2.
    do_reset();
    apply_stimulus('0, '0, 4'b1000);
    wait_floor(2'd1, 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("t6_F", 32'(F), 32'(0));
    check_output("t6_dir", 32'(dir), 32'(0));
    check_output("t6_door", 32'(door), 32'(0));
    check_output("t6_pend", 32'({up_pend, dn_pend, car_pend}), 32'(0));
    @(negedge clk);
    check_output("t6_stays_F", 32'(F), 32'(0));

    // Call at the current floor from rest, then a mixed batch.
    apply_stimulus(4'b0001, '0, '0);
    @(negedge clk);
    check_output("t7_open", 32'(door), 32'(1));
    check_output("t7_up_clear", 32'(up_pend), 32'(0));
    wait_idle(20);
    apply_stimulus(4'b0010, 4'b1000, 4'b0100);
    repeat (3) @(negedge clk);
    apply_stimulus('0, 4'b0010, 4'b0001);
    wait_idle(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_n.md
ELEVATOR_N -- requirements
Module: elevator_n

Interface
REQ-001 Parameter FLOORS, default 8, number of served floors, legal range 2..16.
REQ-002 Parameter FW, default $clog2(FLOORS), width of the floor index.
REQ-003 Parameter TRAVEL_CYCLES, default 2, clock cycles to move one floor, minimum 1.
REQ-004 Parameter DOOR_CYCLES, default 3, clock cycles the door stays open per stop, minimum 1.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 u  in  FLOORS  hall up-call per floor, level or pulse; bit FLOORS-1 is ignored.
REQ-008 d  in  FLOORS  hall down-call per floor, level or pulse; bit 0 is ignored.
REQ-009 i  in  FLOORS  in-car destination request per floor.
REQ-010 F  out  FW  current floor index, 0 = lowest.
REQ-011 dir  out  2  travel direction: 00 idle, 01 up, 10 down; 11 never driven.
REQ-012 door  out  1  door open.
REQ-013 up_pend, dn_pend, car_pend  out  FLOORS each  latched pending requests.

Function
REQ-014 Requests are latched: pend[k] sets on the edge after input bit k is sampled high, and holds until serviced; pulse width 1 cycle is sufficient.
REQ-015 FSM states: IDLE, MOVE, OPEN; dir = 00 only in IDLE.
REQ-016 "Above" = any pending bit (any vector) at an index > F; "below" = any pending bit at an index < F.
REQ-017 IDLE: pending at F -> OPEN next cycle; else above -> MOVE, dir=01; else below -> MOVE, dir=10; above wins when both.
REQ-018 MOVE: travel counter counts TRAVEL_CYCLES cycles, then F steps by +1 (dir 01) or -1 (dir 10) and the counter reloads.
REQ-019 On each floor step, stop (OPEN next cycle) if car_pend[F], or same-direction hall call at F, or nothing pending beyond F in dir (in that case the opposite hall call at F is also served).
REQ-020 F never leaves 0..FLOORS-1; reaching floor 0 or FLOORS-1 in MOVE always stops.
REQ-021 OPEN: door=1 for exactly DOOR_CYCLES cycles; on entry clear car_pend[F] and the hall bit(s) at F served per REQ-019, or both hall bits at F if entered from IDLE.
REQ-022 A new call at F in OPEN matching dir (or any call at F if entered from IDLE) is cleared immediately and restarts the door timer; it never causes departure.
REQ-023 End of OPEN: pending beyond F in dir -> MOVE same dir; else pending in opposite side -> MOVE reversed dir; else IDLE, dir=00.
REQ-024 door=1 only in OPEN; F does not change while door=1.
REQ-025 Simultaneous set and clear of the same pend bit in one cycle: clear wins if the car is in OPEN at that floor, set wins otherwise.
REQ-026 Latency from call to departure from IDLE: 2 cycles (latch, decide).

Reset
REQ-027 While reset is sampled high: state IDLE, F=0, dir=00, door=0, all pend vectors 0, counters 0; inputs ignored.
REQ-028 Reset asserted mid-MOVE or mid-OPEN takes effect at that edge with no partial floor step; operation resumes from IDLE at F=0 on the first edge after deassertion.

Verification (FLOORS=4, TRAVEL_CYCLES=2, DOOR_CYCLES=3)
REQ-029 Reset, pulse i[3] at F=0 -> dir=01 two cycles later, F=1,2,3 every 2 cycles, door=1 for 3 cycles at F=3, then dir=00.
REQ-030 At F=0 moving up to i[3], pulse u[1] before F reaches 1 -> stop at F=1, u_pend[1] cleared, door 3 cycles, continue to F=3.
REQ-031 Car at F=3 idle, d[2] and i[0] pending -> stops at F=2 and F=0 in order; d[1] asserted while descending past F=2 is served at F=1.
REQ-032 Moving up to F=3, pulse d[1] at F=2 -> F=3 served first, reverse to dir=10, stop at F=1, dn_pend[1] cleared.
REQ-033 Door open at F=2, re-pulse i[2] on cycle 2 of open -> door stays 1 for 3 further cycles; u[3] and d[0] never set pend bits.
REQ-034 Assert reset for 1 cycle mid-MOVE between F=1 and F=2 -> next edge F=0, dir=00, door=0, all pend=0.
